// File: rtl/adsr_env_ctrl.sv
// Single-voice ADSR envelope controller: rate-code lookup, tick counter and
// level sequencer driving one voice's amplitude multiplier.

module adsr_rate_rom #(
  parameter int CNT_W = 14
) (
  input  logic [6:0]       code,
  output logic [CNT_W-1:0] period
);
  // Twelve codes per octave: a semitone-spaced mantissa halved once per octave.
  logic [3:0]  oct, idx;
  logic [12:0] mant;

  assign oct = 4'(code / 7'd12);
  assign idx = 4'(code % 7'd12);

  always_comb begin
    case (idx)
      4'd0:    mant = 13'd7540;
      4'd1:    mant = 13'd7117;
      4'd2:    mant = 13'd6717;
      4'd3:    mant = 13'd6340;
      4'd4:    mant = 13'd5985;
      4'd5:    mant = 13'd5649;
      4'd6:    mant = 13'd5332;
      4'd7:    mant = 13'd5032;
      4'd8:    mant = 13'd4750;
      4'd9:    mant = 13'd4483;
      4'd10:   mant = 13'd4232;
      default: mant = 13'd3994;
    endcase
  end

  assign period = CNT_W'(mant >> oct);
endmodule

module adsr_env_ctrl #(
  parameter int CNT_W   = 14,
  parameter int LVL_MAX = 127
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       gate,
  input  logic [6:0] a_rate,
  input  logic [6:0] d_rate,
  input  logic [6:0] s_level,
  input  logic [6:0] r_rate,
  output logic [6:0] level_out,
  output logic [2:0] stage_out,
  output logic       env_tick,
  output logic       busy
);
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } stage_t;

  localparam logic [6:0] LMAX = 7'(LVL_MAX);

  stage_t           stage_q, stage_d;
  logic [6:0]       level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc, period_q, rom_period;
  logic             gate_d, rise, fall, fall_rel, active, tick, step;
  logic [6:0]       rate_code;

  assign rise     = gate & ~gate_d;
  assign fall     = ~gate & gate_d;
  assign fall_rel = fall && (stage_q == ATTACK || stage_q == DECAY || stage_q == SUSTAIN);

  always_comb begin
    case (stage_q)
      ATTACK:  rate_code = a_rate;
      DECAY:   rate_code = d_rate;
      RELEASE: rate_code = r_rate;
      default: rate_code = 7'd0;
    endcase
  end

  adsr_rate_rom #(.CNT_W(CNT_W)) u_rom (.code(rate_code), .period(rom_period));

  // ">=" rather than "==" so a shortened period mid-count still ticks promptly.
  assign active  = (stage_q == ATTACK) || (stage_q == DECAY) || (stage_q == RELEASE);
  assign tick    = active && (cnt_q >= period_q) && (cnt_q != '0);
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q   <= IDLE;
      level_q   <= '0;
      cnt_q     <= '0;
      period_q  <= '0;
      gate_d    <= 1'b0;
      env_tick  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      stage_q   <= stage_d;
      level_q   <= level_d;
      cnt_q     <= cnt_d;
      period_q  <= rom_period;
      gate_d    <= gate;
      env_tick  <= step;
      busy      <= (stage_d != IDLE);
    end
  end

  // next-state
  always_comb begin
    stage_d = stage_q;
    if (rise)          stage_d = ATTACK;
    else if (fall_rel) stage_d = RELEASE;
    else begin
      case (stage_q)
        ATTACK:  if (level_q >= LMAX)    stage_d = DECAY;
        DECAY:   if (level_q <= s_level) stage_d = SUSTAIN;
        RELEASE: if (level_q == '0)      stage_d = IDLE;
        default: stage_d = stage_q;
      endcase
    end
  end

  // level / counter datapath; gate edges keep the level (legato) and restart the count
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    step    = 1'b0;
    if (!rise && !fall_rel) begin
      case (stage_q)
        ATTACK: if (level_q < LMAX) begin
          if (tick) begin level_d = level_q + 7'd1; step = 1'b1; end
          else cnt_d = cnt_inc;
        end
        DECAY: begin
          if (level_q <= s_level) level_d = s_level;
          else if (tick) begin level_d = level_q - 7'd1; step = 1'b1; end
          else cnt_d = cnt_inc;
        end
        SUSTAIN: level_d = s_level;
        RELEASE: if (level_q != '0) begin
          if (tick) begin level_d = level_q - 7'd1; step = 1'b1; end
          else cnt_d = cnt_inc;
        end
        default: level_d = '0;
      endcase
    end
  end

  assign level_out = level_q;
  assign stage_out = stage_q;
endmodule

// File: tb/tb_adsr_env_ctrl.sv
// Directed scenarios plus a randomized run of adsr_env_ctrl against a
// cycle-level behavioural model built from the envelope rules.

module tb_adsr_env_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       gate = 1'b0;
  logic [6:0] a_rate = '0, d_rate = '0, s_level = '0, r_rate = '0;
  logic [6:0] level_out;
  logic [2:0] stage_out;
  logic       env_tick, busy;

  adsr_env_ctrl #(.CNT_W(14), .LVL_MAX(127)) dut (
    .clk(clk), .rst(rst), .gate(gate),
    .a_rate(a_rate), .d_rate(d_rate), .s_level(s_level), .r_rate(r_rate),
    .level_out(level_out), .stage_out(stage_out), .env_tick(env_tick), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0, cyc_n = 0;
  // model state
  int m_stage = 0, m_level = 0, m_cnt = 0, m_per = 0, m_gd = 0, m_tick = 0, m_busy = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc_n);
    end
  endtask

  // exponential table: 7540 * 2^(-code/12), rounded at the octave base then halved per octave
  function automatic int period_of(input int code);
    int  oct = code / 12;
    int  idx = code % 12;
    real m   = 7540.0 * (2.0 ** (-real'(idx) / 12.0));
    return $rtoi(m + 0.5) >> oct;
  endfunction

  task automatic model_update();
    int  ns, nl, nc, code;
    bit  rise, fall, tick;
    if (rst) begin
      m_stage = 0; m_level = 0; m_cnt = 0; m_per = 0; m_gd = 0; m_tick = 0; m_busy = 0;
      return;
    end
    rise = gate && (m_gd == 0);
    fall = !gate && (m_gd == 1);
    tick = (m_stage == 1 || m_stage == 2 || m_stage == 4) && m_cnt >= m_per && m_cnt != 0;
    code = (m_stage == 1) ? a_rate : (m_stage == 2) ? d_rate : (m_stage == 4) ? r_rate : 0;
    ns = m_stage; nl = m_level; nc = 0; m_tick = 0;
    if (rise) ns = 1;
    else if (fall && (m_stage == 1 || m_stage == 2 || m_stage == 3)) ns = 4;
    else case (m_stage)
      1: if (m_level >= 127) ns = 2;
         else if (tick) begin nl = m_level + 1; m_tick = 1; end
         else nc = (m_cnt + 1 > 16383) ? 16383 : m_cnt + 1;
      2: if (m_level <= s_level) begin ns = 3; nl = s_level; end
         else if (tick) begin nl = m_level - 1; m_tick = 1; end
         else nc = (m_cnt + 1 > 16383) ? 16383 : m_cnt + 1;
      3: nl = s_level;
      4: if (m_level == 0) ns = 0;
         else if (tick) begin nl = m_level - 1; m_tick = 1; end
         else nc = (m_cnt + 1 > 16383) ? 16383 : m_cnt + 1;
      default: nl = 0;
    endcase
    m_stage = ns; m_level = nl; m_cnt = nc; m_per = period_of(code);
    m_gd = gate; m_busy = (ns != 0);
  endtask

  // one clock: model steps on the edge, outputs compared on the falling edge
  task automatic cyc();
    @(posedge clk);
    model_update();
    @(negedge clk);
    cyc_n++;
    chk("level", level_out, m_level);
    chk("stage", stage_out, m_stage);
    chk("env_tick", env_tick, m_tick);
    chk("busy", busy, m_busy);
  endtask

  // which: 0 = stage, 1 = level
  task automatic wait_for(input int which, input int val, input int lim, input string tag);
    int got;
    for (int i = 0; i < lim; i++) begin
      got = (which == 0) ? int'(stage_out) : int'(level_out);
      if (got == val) return;
      cyc();
    end
    got = (which == 0) ? int'(stage_out) : int'(level_out);
    if (got != val) chk(tag, got, val);
  endtask

  int t0, t1, t2;
  bit pulse;

  initial begin
    cyc(); cyc();
    chk("rst_level", level_out, 0);
    chk("rst_stage", stage_out, 0);
    rst = 1'b0;
    cyc();

    // fastest attack, decay to sustain, live sustain change, release
    a_rate = 7'd127; d_rate = 7'd127; s_level = 7'd100; r_rate = 7'd127;
    gate = 1'b1;
    cyc();
    chk("atk_stage", stage_out, 1);
    t0 = cyc_n;
    wait_for(1, 127, 1000, "atk_timeout");
    chk("atk_len", cyc_n - t0, 635);
    cyc();
    chk("dec_stage", stage_out, 2);
    t0 = cyc_n;
    wait_for(0, 3, 400, "dec_timeout");
    chk("dec_len", cyc_n - t0, 136);
    chk("sus_level", level_out, 100);
    s_level = 7'd90;
    cyc();
    chk("sus_track", level_out, 90);
    gate = 1'b0;
    cyc();
    chk("rel_stage", stage_out, 4);
    t0 = cyc_n;
    wait_for(1, 0, 1000, "rel_timeout");
    chk("rel_len", cyc_n - t0, 450);
    cyc();
    chk("idle_stage", stage_out, 0);
    chk("idle_busy", busy, 0);

    // release from mid-attack, legato retrigger, then async reset mid-release
    gate = 1'b1;
    cyc();
    wait_for(1, 60, 1000, "rtg_up_timeout");
    gate = 1'b0;
    wait_for(1, 57, 100, "rtg_dn_timeout");
    chk("rtg_rel", stage_out, 4);
    gate = 1'b1;
    cyc();
    chk("rtg_stage", stage_out, 1);
    chk("rtg_level", level_out, 57);
    gate = 1'b0;
    wait_for(1, 50, 200, "arst_timeout");
    #2 rst = 1'b1;
    #1;
    chk("arst_level", level_out, 0);
    chk("arst_stage", stage_out, 0);
    chk("arst_tick", env_tick, 0);
    chk("arst_busy", busy, 0);
    cyc();
    rst = 1'b0;
    cyc();

    // rate code shortened while the count is far past the new period
    a_rate = 7'd0;
    gate = 1'b1;
    for (int i = 0; i < 3001; i++) cyc();
    a_rate = 7'd127;
    cyc();
    chk("rchg_early", env_tick, 0);
    cyc();
    chk("rchg_tick", env_tick, 1);
    gate = 1'b0;
    cyc();
    wait_for(0, 0, 2000, "rchg_idle_timeout");

    // slowest rate tick spacing
    a_rate = 7'd0;
    gate = 1'b1;
    t1 = -1; t2 = -1;
    for (int i = 0; i < 16000 && t2 < 0; i++) begin
      cyc();
      if (env_tick) begin
        if (t1 < 0) t1 = cyc_n; else t2 = cyc_n;
      end
    end
    chk("slow_gap", t2 - t1, 7541);
    gate = 1'b0;
    cyc();

    // randomized gate / rate / sustain activity
    pulse = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      if (pulse) begin gate = 1'b0; pulse = 1'b0; end
      else if ($urandom_range(0, 299) == 0) gate = ~gate;
      else if (!gate && $urandom_range(0, 799) == 0) begin gate = 1'b1; pulse = 1'b1; end
      if ($urandom_range(0, 399) == 0)
        a_rate = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(0, 127)) : 7'(96 + $urandom_range(0, 31));
      if ($urandom_range(0, 399) == 0) d_rate = 7'(96 + $urandom_range(0, 31));
      if ($urandom_range(0, 399) == 0) r_rate = 7'(96 + $urandom_range(0, 31));
      if ($urandom_range(0, 149) == 0) s_level = 7'($urandom_range(0, 127));
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_chk, n_err);
    $finish;
  end
endmodule
